// File: rtl/sysid_info_regs_if.sv
// Avalon-MM slave bus for the system-ID / board-info register block.
// Fixed read latency of one cycle; there is no waitrequest.
interface sysid_info_regs_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_info_regs.sv
// System-ID / board-info slave: ID and timestamp words, coherent 64-bit uptime,
// seconds counter, capability word and byte-writable scratch registers.
module sysid_info_regs #(
    parameter logic [31:0] SYSID_VALUE = 32'hA5A5_0001,
    parameter logic [31:0] TIMESTAMP   = 32'd0,
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          NUM_SCRATCH = 2,
    parameter int          ADDR_W      = 4
) (
    input logic          clock,
    input logic          reset,
    sysid_info_regs_if.slave bus
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [31:0] CAPS = {16'h0, 8'(ADDR_W), 8'(NUM_SCRATCH)};
    localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TS     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CYC_LO = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CYC_HI = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_SEC    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CAPS   = ADDR_W'(5);

    logic [63:0]                  cyc_cnt;
    logic [31:0]                  hi_shadow;
    logic [31:0]                  sec_cnt;
    logic [PW-1:0]                presc;
    logic [NUM_SCRATCH-1:0][31:0] scratch;
    logic [31:0]                  rd_mux;
    logic                         rd_en;
    logic                         sec_clr;

    // A coincident write wins: the read is dropped entirely.
    assign rd_en   = bus.read & ~bus.write;
    assign sec_clr = bus.write && (bus.address == A_SEC);

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_ID:     rd_mux = SYSID_VALUE;
            A_TS:     rd_mux = TIMESTAMP;
            A_CYC_LO: rd_mux = cyc_cnt[31:0];
            A_CYC_HI: rd_mux = hi_shadow;
            A_SEC:    rd_mux = sec_cnt;
            A_CAPS:   rd_mux = CAPS;
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++)
                    if (bus.address == ADDR_W'(6 + i)) rd_mux = scratch[i];
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_cnt   <= '0;
            hi_shadow <= '0;
            sec_cnt   <= '0;
            presc     <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
            if (sec_clr) begin
                presc   <= '0;
                sec_cnt <= '0;
            end else if (presc == PW'(CLK_HZ - 1)) begin
                presc   <= '0;
                sec_cnt <= sec_cnt + 32'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            // Latch the upper half with the same sample as the low-word read.
            if (rd_en && (bus.address == A_CYC_LO))
                hi_shadow <= cyc_cnt[63:32];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch <= '0;
        end else if (bus.write) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (bus.address == ADDR_W'(6 + i))
                    for (int b = 0; b < 4; b++)
                        if (bus.byteenable[b])
                            scratch[i][8*b +: 8] <= bus.writedata[8*b +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= rd_en;
            if (rd_en) bus.readdata <= rd_mux;
        end
    end
endmodule
